// File: rtl/e203_dtcm_ram_initiator_pkg.sv
// rtl/e203_dtcm_ram_initiator_pkg.sv - DTCM initiator widths and state encoding
// E203_DTCM_INIT_EN selects the power-up zero sweep in the top module.
package e203_dtcm_ram_initiator_pkg;

    localparam int E203_DTCM_RAM_AW = 13;
    localparam int E203_DTCM_RAM_DW = 32;
    localparam int E203_DTCM_RAM_MW = E203_DTCM_RAM_DW / 8;
    localparam int E203_DTCM_RAM_DP = 8192;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

endpackage

// File: rtl/e203_dtcm_rsp_fifo.sv
// rtl/e203_dtcm_rsp_fifo.sv - two-entry response FIFO {read flag, rdata}
// Head reads as zero while empty so the response outputs idle at zero.
module e203_dtcm_rsp_fifo
    import e203_dtcm_ram_initiator_pkg::*;
#(
    parameter int W = E203_DTCM_RAM_DW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head = (r_cnt != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/e203_dtcm_ram_initiator.sv
// rtl/e203_dtcm_ram_initiator.sv - DTCM SRAM initiator with in-order 2-deep responses
// Define E203_DTCM_INIT_EN to zero-sweep the SRAM after reset before accepting commands.
module e203_dtcm_ram_initiator
    import e203_dtcm_ram_initiator_pkg::*;
#(
    parameter int AW = E203_DTCM_RAM_AW,
    parameter int DW = E203_DTCM_RAM_DW,
    parameter int MW = E203_DTCM_RAM_MW,
    parameter int DP = E203_DTCM_RAM_DP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_read,
    output logic          init_done,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic          w_run;
    logic          w_sweep;
    logic [AW-1:0] w_sweep_addr;
    logic          w_fire;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic [1:0]    w_fifo_cnt;
    logic [DW:0]   w_head;
    logic [DW:0]   w_push_data;
    logic          r_inflight;
    logic          r_infl_read;

`ifdef E203_DTCM_INIT_EN
    localparam logic [AW-1:0] LP_INIT_LAST = AW'(DP - 1);

    init_state_e   r_state;
    init_state_e   w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic [AW-1:0] w_init_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // The counter parks on the last address so DP=2**AW never wraps into a second sweep.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_run          = (r_state == ST_RUN);
        w_sweep        = (r_state == ST_INIT) & rst_n;
        w_sweep_addr   = r_init_cnt;
        if (r_state == ST_INIT) begin
            if (r_init_cnt == LP_INIT_LAST) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_init_cnt_nxt = r_init_cnt + AW'(1);
            end
        end
    end
`else
    assign w_run        = 1'b1;
    assign w_sweep      = 1'b0;
    assign w_sweep_addr = '0;
`endif

    assign init_done = w_run;

    // Occupancy counts the buffered entries plus the one still in the SRAM pipe.
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign cmd_ready = rst_n & w_run & (w_occ <= 3'd1);
    assign w_fire    = cmd_valid & cmd_ready;

    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wem  = '0;
        ram_din  = '0;
        if (w_sweep) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = w_sweep_addr;
            ram_wem  = '1;
        end else if (w_fire) begin
            ram_cs   = 1'b1;
            ram_we   = ~cmd_read;
            ram_addr = cmd_addr;
            ram_wem  = cmd_wmask;
            ram_din  = cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_infl_read <= 1'b0;
        end else begin
            r_inflight <= w_fire;
            if (w_fire) begin
                r_infl_read <= cmd_read;
            end
        end
    end

    assign w_push_data = {r_infl_read, r_infl_read ? ram_dout : {DW{1'b0}}};

    e203_dtcm_rsp_fifo #(
        .W (DW + 1)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_cnt       (w_fifo_cnt)
    );

    assign rsp_valid = (w_fifo_cnt != 2'd0);
    assign rsp_read  = w_head[DW];
    assign rsp_rdata = w_head[DW-1:0];

endmodule

// File: tb/tb_e203_dtcm_ram_initiator.sv
// tb/tb_e203_dtcm_ram_initiator.sv - bench for e203_dtcm_ram_initiator (honours E203_DTCM_INIT_EN)
module tb_e203_dtcm_ram_initiator;

`ifdef E203_DTCM_INIT_EN
    localparam int TB_DP    = 16;
    localparam int INIT_CYC = TB_DP;
    localparam logic EXP_DONE_RST = 1'b0;
`else
    localparam int TB_DP    = 8192;
    localparam int INIT_CYC = 0;
    localparam logic EXP_DONE_RST = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [12:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_read;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        ram_cs, ram_we;
    logic [12:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    e203_dtcm_ram_initiator #(
        .AW(13), .DW(32), .MW(4), .DP(TB_DP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_read(rsp_read),
        .init_done(init_done),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // SRAM with one-cycle registered read data
    logic [31:0] sram [8192];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int rel    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rel = 0;
        else rel++;
    end

    typedef struct { logic rd; logic [31:0] d; int c; } rsp_t;
    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    logic [31:0] ref_mem [int];

    // Model: a response is due two cycles after its fire, in order; capacity is two outstanding.
    always @(negedge clk) begin
        logic v_e, pop_e, fire, run_e;
        int outst;
        logic [31:0] cur;
        rsp_t e;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_ram_cs", ram_cs, 0);
        end else begin
            run_e = (rel >= INIT_CYC);
            chk("init_done", init_done, run_e);
            v_e = (exp_q.size() > 0) && (cyc - exp_q[0].c >= 2);
            chk("rsp_valid", rsp_valid, v_e);
            if (v_e) begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].d);
                chk("rsp_read", rsp_read, exp_q[0].rd);
            end
            pop_e = v_e && rsp_ready;
            outst = exp_q.size() - (pop_e ? 1 : 0);
            chk("cmd_ready", cmd_ready, run_e && (outst <= 1));
            fire = cmd_valid && cmd_ready;
            if (!run_e) begin
                chk("sweep_cs", ram_cs, 1);
                chk("sweep_we", ram_we, 1);
                chk("sweep_addr", ram_addr, rel);
                chk("sweep_wem", ram_wem, 4'hF);
                chk("sweep_din", ram_din, 0);
                ref_mem[rel] = 32'h0;
            end else if (fire) begin
                chk("fire_cs", ram_cs, 1);
                chk("fire_we", ram_we, !cmd_read);
                chk("fire_addr", ram_addr, cmd_addr);
                chk("fire_wem", ram_wem, cmd_wmask);
                chk("fire_din", ram_din, cmd_wdata);
            end else begin
                chk("idle_cs", ram_cs, 0);
                chk("idle_we", ram_we, 0);
            end
            if (pop_e) void'(exp_q.pop_front());
            if (fire) begin
                cur = ref_mem.exists(int'(cmd_addr)) ? ref_mem[int'(cmd_addr)] : 32'h0;
                e.rd = cmd_read;
                e.c  = cyc;
                if (cmd_read) begin
                    e.d = cur;
                end else begin
                    e.d = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (cmd_wmask[b]) cur[8*b +: 8] = cmd_wdata[8*b +: 8];
                    ref_mem[int'(cmd_addr)] = cur;
                end
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        rsp_t g;
        if (rst_n && rsp_valid && rsp_ready) begin
            g.rd = rsp_read;
            g.d  = rsp_rdata;
            g.c  = cyc;
            got_q.push_back(g);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rd, input logic [12:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int fc);
        int n = 0;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_timeout", cmd_ready, 1);
        fc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_run(output int rel_at);
        int n = 0;
        @(negedge clk);
        while (!init_done && n < TB_DP + 8) begin
            @(negedge clk);
            n++;
        end
        chk("wait_run", init_done, 1);
        rel_at = rel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fc, fc_r, nf, f_first, f_last, rel_at;
        logic fired;

        for (int i = 0; i < 8192; i++) sram[i] = 32'h0;
`ifdef E203_DTCM_INIT_EN
        for (int i = 0; i < TB_DP; i++) sram[i] = 32'hA5A5_A5A5;
`endif
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0;
        idle(3);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_read", rsp_read, 0);
        chk("reset_ram", {ram_cs, ram_we, ram_addr, ram_wem, ram_din}, 0);
        chk("reset_init_done", init_done, EXP_DONE_RST);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_run(rel_at);
        chk("init_cycle", rel_at, INIT_CYC);

        // sweep leaves address 5 zero
        got_q.delete();
        send(1'b1, 13'd5, 32'h0, 4'h0, fc);
        idle(4);
        chk("rd5_cnt", got_q.size(), 1);
        if (got_q.size() >= 1) chk("rd5_data", got_q[0].d, 32'h0);

        // write then read
        got_q.delete();
        send(1'b0, 13'h10, 32'hDEADBEEF, 4'hF, fc);
        send(1'b1, 13'h10, 32'h0, 4'h0, fc_r);
        idle(4);
        chk("t1_cnt", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1_wr_rsp", {got_q[0].rd, got_q[0].d}, {1'b0, 32'h0});
            chk("t1_rd_rsp", {got_q[1].rd, got_q[1].d}, {1'b1, 32'hDEADBEEF});
            chk("t1_latency", got_q[1].c - fc_r, 2);
        end

        // partial byte mask merge
        got_q.delete();
        send(1'b0, 13'h20, 32'h11223344, 4'hF, fc);
        send(1'b0, 13'h20, 32'hAABBCCDD, 4'h5, fc);
        send(1'b1, 13'h20, 32'h0, 4'h0, fc);
        idle(4);
        chk("t2_cnt", got_q.size(), 3);
        if (got_q.size() == 3) chk("t2_merge", got_q[2].d, 32'h11BB33DD);

        // back-pressure: two fires, then stall, then drain
        for (int i = 0; i < 4; i++) send(1'b0, 13'h30 + 13'(i), 32'hC0DE0000 + i, 4'hF, fc);
        idle(4);
        got_q.delete();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 13'h30;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fired = cmd_ready;
            @(posedge clk);
            #1;
            if (fired) begin nf++; cmd_addr++; end
        end
        chk("t3_fires", nf, 2);
        @(negedge clk);
        chk("t3_stalled", cmd_ready, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && nf < 4; i++) begin
            @(negedge clk);
            fired = cmd_ready;
            @(posedge clk);
            #1;
            if (fired) begin nf++; cmd_addr++; end
        end
        cmd_valid = 1'b0;
        idle(5);
        chk("t3_resumed", nf, 4);
        chk("t3_cnt", got_q.size(), 4);
        if (got_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t3_order", got_q[k].d, 32'hC0DE0000 + k);
            chk("t3_drain_gap", got_q[1].c - got_q[0].c, 1);
        end

        // back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) send(1'b0, 13'(i), 32'h1000 + i, 4'hF, fc);
        idle(4);
        got_q.delete();
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 13'd0;
        nf = 0; f_first = -1; f_last = -1;
        for (int i = 0; i < 12 && nf < 8; i++) begin
            @(negedge clk);
            fired = cmd_ready;
            if (fired) begin
                if (f_first < 0) f_first = cyc;
                f_last = cyc;
            end
            @(posedge clk);
            #1;
            if (fired) begin nf++; cmd_addr++; end
        end
        cmd_valid = 1'b0;
        idle(5);
        chk("t4_fires", nf, 8);
        chk("t4_fire_span", f_last - f_first, 7);
        chk("t4_cnt", got_q.size(), 8);
        if (got_q.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("t4_data", got_q[k].d, 32'h1000 + k);
            chk("t4_rsp_span", got_q[7].c - got_q[0].c, 7);
            chk("t4_first_lat", got_q[0].c - f_first, 2);
        end

        // reset with one buffered and one in flight
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 13'h30;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fired = cmd_ready;
            @(posedge clk);
            #1;
            if (fired) cmd_addr++;
        end
        chk("t6_pre_valid", rsp_valid, 1);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_cmd_ready", cmd_ready, 0);
        got_q.delete();
        idle(3);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_run(rel_at);
        idle(8);
        chk("t6_no_stale", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
